// File: rtl/d_latch_pkg.sv
//==============================================================================
// Module      : d_latch_pkg
// Description : Shared constants and helpers for the gated D latch bank.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package d_latch_pkg;

    localparam int unsigned c_default_width = 1;

    // Both NAND inputs high means the cross-coupled pair holds its state.
    function automatic logic sr_hold(input logic s_n, input logic r_n);
        return s_n & r_n;
    endfunction

    // With at most one of s_n/r_n low, the pair resolves to the set request.
    function automatic logic sr_value(input logic s_n);
        return ~s_n;
    endfunction

endpackage : d_latch_pkg

`default_nettype wire

// File: rtl/d_latch_cell.sv
//==============================================================================
// Module      : d_latch_cell
// Description : One-bit gated D latch as an SR NAND-pair cell with async reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module d_latch_cell
    import d_latch_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_n
);

    logic w_s_n;
    logic w_r_n;
    logic r_q;

    // Gating d into both set and reset makes S=R=1 impossible by construction.
    assign w_s_n = ~(en & d);
    assign w_r_n = ~(en & ~d);

    always_latch begin
        if (rst) begin
            r_q <= RST_BIT;
        end else if (!sr_hold(w_s_n, w_r_n)) begin
            r_q <= sr_value(w_s_n);
        end
    end

    assign q   = r_q;
    assign q_n = ~r_q;

endmodule : d_latch_cell

`default_nettype wire

// File: rtl/d_latch.sv
//==============================================================================
// Module      : d_latch
// Description : Bank of gated D latches with a clk-synchronised copy and strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module d_latch
    import d_latch_pkg::*;
#(
    parameter int unsigned       WIDTH   = c_default_width,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] q_sync,
    output logic             changed
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_n;
    logic [WIDTH-1:0] r_q_sync;
    logic             r_changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_latch_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .rst (rst),
            .en  (en),
            .d   (d[i]),
            .q   (w_q[i]),
            .q_n (w_q_n[i])
        );
    end

    // Compare against the pre-edge q_sync so the strobe lines up with the update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_sync  <= RST_VAL;
            r_changed <= 1'b0;
        end else begin
            r_q_sync  <= w_q;
            r_changed <= (w_q != r_q_sync);
        end
    end

    assign q       = w_q;
    assign q_n     = w_q_n;
    assign q_sync  = r_q_sync;
    assign changed = r_changed;

endmodule : d_latch

`default_nettype wire

// File: tb/tb_d_latch.sv
//==============================================================================
// Module      : tb_d_latch
// Description : Directed self-checking bench for the d_latch bank (1 and 8 bits).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_d_latch;

    logic       clk;
    logic       rst;
    logic       en;
    logic [0:0] d;
    logic [0:0] q;
    logic [0:0] q_n;
    logic [0:0] q_sync;
    logic       changed;

    logic       en8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] q8_n;
    logic [7:0] q8_sync;
    logic       changed8;

    int n_tests;
    int n_fail;

    d_latch #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d       (d),
        .q       (q),
        .q_n     (q_n),
        .q_sync  (q_sync),
        .changed (changed)
    );

    d_latch #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .en      (en8),
        .d       (d8),
        .q       (q8),
        .q_n     (q8_n),
        .q_sync  (q8_sync),
        .changed (changed8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply (en,d) just after a falling edge, check q away from the rising edge.
    task automatic step(input logic e, input logic v, input logic exp_q, input string tag);
        @(negedge clk);
        en = e;
        d  = v;
        #2;
        chk(tag, {7'b0, q}, {7'b0, exp_q});
        #8;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        en  = 1'b1;
        d   = 1'b1;
        en8 = 1'b1;
        d8  = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q",       {7'b0, q},       8'h00);
        chk("rst_q_n",     {7'b0, q_n},     8'h01);
        chk("rst_q_sync",  {7'b0, q_sync},  8'h00);
        chk("rst_changed", {7'b0, changed}, 8'h00);
        chk("rst_q8",      q8,              8'h00);
        chk("rst_q8_n",    q8_n,            8'hFF);

        rst = 1'b0;
        #1;
        chk("release_q",   {7'b0, q},   8'h01);
        chk("release_q_n", {7'b0, q_n}, 8'h00);

        // Re-reset and release with en=0 so the sequence starts from q=0.
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        d   = 1'b0;
        #2;
        rst = 1'b0;
        #2;
        chk("rerst_q", {7'b0, q}, 8'h00);

        step(1'b0, 1'b0, 1'b0, "seq0_00");
        step(1'b1, 1'b0, 1'b0, "seq1_10");
        step(1'b0, 1'b1, 1'b0, "seq2_01_hold0");
        step(1'b1, 1'b1, 1'b1, "seq3_11");
        step(1'b0, 1'b0, 1'b1, "seq4_00_hold1");
        step(1'b1, 1'b0, 1'b0, "seq5_10");
        step(1'b0, 1'b1, 1'b0, "seq6_01_hold0");
        chk("seq_q_n", {7'b0, q_n}, 8'h01);

        // Transparency: d toggles between edges; q follows with no clock.
        @(negedge clk);
        en = 1'b1;
        d  = 1'b0;
        @(posedge clk);
        #1;
        chk("tr_pre_q_sync", {7'b0, q_sync}, 8'h00);
        @(negedge clk);
        d = 1'b1;
        #1;
        chk("tr_q_rise", {7'b0, q}, 8'h01);
        d = 1'b0;
        #1;
        chk("tr_q_fall", {7'b0, q}, 8'h00);
        @(posedge clk);
        #1;
        chk("tr_q_sync",  {7'b0, q_sync},  8'h00);
        chk("tr_changed", {7'b0, changed}, 8'h00);

        // Sync/strobe.
        @(negedge clk);
        d = 1'b1;
        #1;
        chk("st_q", {7'b0, q}, 8'h01);
        @(posedge clk);
        #1;
        chk("st_q_sync",   {7'b0, q_sync},  8'h01);
        chk("st_changed1", {7'b0, changed}, 8'h01);
        @(posedge clk);
        #1;
        chk("st_changed0", {7'b0, changed}, 8'h00);
        chk("st_q_sync2",  {7'b0, q_sync},  8'h01);

        // Async reset while holding a 1.
        @(negedge clk);
        en = 1'b0;
        d  = 1'b0;
        #1;
        chk("ar_hold1", {7'b0, q}, 8'h01);
        rst = 1'b1;
        #1;
        chk("ar_q",       {7'b0, q},       8'h00);
        chk("ar_q_n",     {7'b0, q_n},     8'h01);
        chk("ar_q_sync",  {7'b0, q_sync},  8'h00);
        chk("ar_changed", {7'b0, changed}, 8'h00);
        rst = 1'b0;
        #1;
        chk("ar_post_q", {7'b0, q}, 8'h00);

        // Eight-bit bank: capture A5, then hold while d changes.
        @(negedge clk);
        en8 = 1'b1;
        d8  = 8'hA5;
        #1;
        chk("w8_transp", q8, 8'hA5);
        en8 = 1'b0;
        #1;
        d8 = 8'h5A;
        #1;
        chk("w8_q",   q8,   8'hA5);
        chk("w8_q_n", q8_n, 8'h5A);
        @(posedge clk);
        #1;
        chk("w8_q_sync", q8_sync, 8'hA5);
        chk("w8_changed", {7'b0, changed8}, 8'h01);
        @(negedge clk);
        en8 = 1'b1;
        #1;
        chk("w8_reopen", q8, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_d_latch

`default_nettype wire
